// File: rtl/ex_wb_collector.sv
// ex_wb_collector: buffers execute-stage results per source and arbitrates them
// round-robin onto registered scoreboard writeback ports.
//
// Ports:
//   clk_i, rst_i       clock, synchronous active-high reset
//   flush_i            discard every buffered and in-flight result
//   src_valid_i        per-source result valid
//   src_ready_o        per-source FIFO has room (registered)
//   src_trans_id_i     per-source scoreboard entry id
//   src_result_i       per-source result data
//   src_exception_i    per-source exception payload
//   wb_valid_o         per-port writeback valid (one cycle per entry)
//   wb_trans_id_o      per-port written entry id
//   wb_result_o        per-port written data
//   wb_exception_o     per-port written exception
//   overflow_o         sticky: a source was valid while its ready was low

package ex_wb_collector_pkg;
  localparam int unsigned XLEN          = 32;
  localparam int unsigned TRANS_ID_BITS = 3;

  typedef struct packed {
    logic [XLEN-1:0] cause;
    logic [XLEN-1:0] tval;
    logic            valid;
  } exception_t;

  typedef struct packed {
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [XLEN-1:0]          result;
    exception_t               ex;
  } wb_entry_t;
endpackage

module ex_wb_collector
  import ex_wb_collector_pkg::*;
#(
  parameter int unsigned NR_SRC      = 5,
  parameter int unsigned NR_WB_PORTS = 2,
  parameter int unsigned DEPTH       = 2
) (
  input  logic                                        clk_i,
  input  logic                                        rst_i,
  input  logic                                        flush_i,
  input  logic       [NR_SRC-1:0]                     src_valid_i,
  output logic       [NR_SRC-1:0]                     src_ready_o,
  input  logic       [NR_SRC-1:0][TRANS_ID_BITS-1:0]  src_trans_id_i,
  input  logic       [NR_SRC-1:0][XLEN-1:0]           src_result_i,
  input  exception_t [NR_SRC-1:0]                     src_exception_i,
  output logic       [NR_WB_PORTS-1:0]                wb_valid_o,
  output logic       [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_o,
  output logic       [NR_WB_PORTS-1:0][XLEN-1:0]      wb_result_o,
  output exception_t [NR_WB_PORTS-1:0]                wb_exception_o,
  output logic                                        overflow_o
);

  localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned SRC_W  = (NR_SRC > 1) ? $clog2(NR_SRC) : 1;
  localparam int unsigned PORT_W = (NR_WB_PORTS > 1) ? $clog2(NR_WB_PORTS) : 1;

  wb_entry_t        mem_q  [NR_SRC][DEPTH];
  logic [PTR_W-1:0] rptr_q [NR_SRC];
  logic [PTR_W-1:0] wptr_q [NR_SRC];
  logic [CNT_W-1:0] cnt_q  [NR_SRC];
  logic [CNT_W-1:0] cnt_d  [NR_SRC];
  logic [NR_SRC-1:0] ready_q;
  logic [SRC_W-1:0]  rr_q;
  logic [SRC_W-1:0]  rr_d;

  wb_entry_t         in_entry   [NR_SRC];
  wb_entry_t         cand_entry [NR_SRC];
  logic [NR_SRC-1:0] accept;
  logic [NR_SRC-1:0] cand;
  logic [NR_SRC-1:0] grant;
  logic [NR_SRC-1:0] push;
  logic [NR_SRC-1:0] pop;
  logic [NR_WB_PORTS-1:0] port_used;
  logic [SRC_W-1:0]       port_src [NR_WB_PORTS];

  assign src_ready_o = ready_q;

  // Per-source candidate: FIFO head if any, else the accepted incoming entry.
  always_comb begin
    for (int unsigned s = 0; s < NR_SRC; s++) begin
      in_entry[s].trans_id = src_trans_id_i[s];
      in_entry[s].result   = src_result_i[s];
      in_entry[s].ex       = src_exception_i[s];
      accept[s]            = src_valid_i[s] & ready_q[s];
      cand[s]              = (cnt_q[s] != '0) | accept[s];
      cand_entry[s]        = (cnt_q[s] != '0) ? mem_q[s][rptr_q[s]] : in_entry[s];
    end
  end

  // Round-robin scan from rr_q; first NR_WB_PORTS candidates fill ports in order.
  always_comb begin
    int unsigned n;
    int unsigned idx;
    grant     = '0;
    port_used = '0;
    rr_d      = rr_q;
    n         = 0;
    idx       = 0;
    for (int unsigned p = 0; p < NR_WB_PORTS; p++) port_src[p] = '0;
    for (int unsigned i = 0; i < NR_SRC; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NR_SRC) idx = idx - NR_SRC;
      if (cand[SRC_W'(idx)] && (n < NR_WB_PORTS)) begin
        grant[SRC_W'(idx)]      = 1'b1;
        port_used[PORT_W'(n)]   = 1'b1;
        port_src[PORT_W'(n)]    = SRC_W'(idx);
        rr_d                    = (idx == NR_SRC - 1) ? '0 : SRC_W'(idx + 1);
        n                       = n + 1;
      end
    end
  end

  // A granted head pops; an accepted entry is stored unless it was bypassed.
  always_comb begin
    for (int unsigned s = 0; s < NR_SRC; s++) begin
      pop[s]   = grant[s] & (cnt_q[s] != '0);
      push[s]  = accept[s] & ~(grant[s] & (cnt_q[s] == '0));
      cnt_d[s] = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
    end
  end

  // FIFO state, round-robin pointer, writeback registers and sticky overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned s = 0; s < NR_SRC; s++) begin
        cnt_q[s]  <= '0;
        rptr_q[s] <= '0;
        wptr_q[s] <= '0;
        for (int unsigned d = 0; d < DEPTH; d++) mem_q[s][d] <= '0;
      end
      ready_q        <= '1;
      rr_q           <= '0;
      wb_valid_o     <= '0;
      wb_trans_id_o  <= '0;
      wb_result_o    <= '0;
      wb_exception_o <= '0;
      overflow_o     <= 1'b0;
    end else begin
      // Flush-cycle inputs are discarded outright, so they cannot overflow.
      overflow_o <= overflow_o | (~flush_i & (|(src_valid_i & ~ready_q)));
      if (flush_i) begin
        for (int unsigned s = 0; s < NR_SRC; s++) begin
          cnt_q[s]  <= '0;
          rptr_q[s] <= '0;
          wptr_q[s] <= '0;
        end
        ready_q    <= '1;
        rr_q       <= '0;
        wb_valid_o <= '0;
      end else begin
        for (int unsigned s = 0; s < NR_SRC; s++) begin
          if (push[s]) begin
            mem_q[s][wptr_q[s]] <= in_entry[s];
            wptr_q[s]           <= wptr_q[s] + PTR_W'(1);
          end
          if (pop[s]) rptr_q[s] <= rptr_q[s] + PTR_W'(1);
          cnt_q[s]   <= cnt_d[s];
          ready_q[s] <= (cnt_d[s] < CNT_W'(DEPTH));
        end
        rr_q <= rr_d;
        for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
          wb_valid_o[p] <= port_used[p];
          if (port_used[p]) begin
            wb_trans_id_o[p]  <= cand_entry[port_src[p]].trans_id;
            wb_result_o[p]    <= cand_entry[port_src[p]].result;
            wb_exception_o[p] <= cand_entry[port_src[p]].ex;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ex_wb_collector.sv
// tb_ex_wb_collector: directed scenarios plus randomized traffic, checked every
// cycle against a queue-based reference model of the collector.
module tb_ex_wb_collector;
  import ex_wb_collector_pkg::*;

  localparam int NR_SRC      = 5;
  localparam int NR_WB_PORTS = 2;
  localparam int DEPTH       = 2;

  logic                                         clk_i;
  logic                                         rst_i;
  logic                                         flush_i;
  logic       [NR_SRC-1:0]                      src_valid_i;
  logic       [NR_SRC-1:0]                      src_ready_o;
  logic       [NR_SRC-1:0][TRANS_ID_BITS-1:0]   src_trans_id_i;
  logic       [NR_SRC-1:0][XLEN-1:0]            src_result_i;
  exception_t [NR_SRC-1:0]                      src_exception_i;
  logic       [NR_WB_PORTS-1:0]                 wb_valid_o;
  logic       [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0] wb_trans_id_o;
  logic       [NR_WB_PORTS-1:0][XLEN-1:0]       wb_result_o;
  exception_t [NR_WB_PORTS-1:0]                 wb_exception_o;
  logic                                         overflow_o;

  ex_wb_collector #(
    .NR_SRC(NR_SRC), .NR_WB_PORTS(NR_WB_PORTS), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .src_valid_i(src_valid_i), .src_ready_o(src_ready_o),
    .src_trans_id_i(src_trans_id_i), .src_result_i(src_result_i),
    .src_exception_i(src_exception_i),
    .wb_valid_o(wb_valid_o), .wb_trans_id_o(wb_trans_id_o),
    .wb_result_o(wb_result_o), .wb_exception_o(wb_exception_o),
    .overflow_o(overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int vectors    = 0;
  int miscompares = 0;
  bit check_en   = 0;

  // Reference model: one queue per source, expected writeback registers.
  wb_entry_t mq [NR_SRC][$];
  logic      exp_valid [NR_WB_PORTS];
  wb_entry_t exp_wb    [NR_WB_PORTS];
  logic      exp_ovf;
  int        m_rr;
  int        m_n, m_k, m_last;
  bit        m_acc [NR_SRC];
  bit        m_byp [NR_SRC];
  wb_entry_t m_inc [NR_SRC];

  function automatic bit mready(int s);
    return mq[s].size() < DEPTH;
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < NR_SRC; s++) mq[s].delete();
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        exp_valid[p] = 1'b0;
        exp_wb[p]    = '0;
      end
      exp_ovf = 1'b0;
      m_rr    = 0;
    end else if (flush_i) begin
      for (int s = 0; s < NR_SRC; s++) mq[s].delete();
      for (int p = 0; p < NR_WB_PORTS; p++) exp_valid[p] = 1'b0;
      m_rr = 0;
    end else begin
      for (int s = 0; s < NR_SRC; s++) begin
        m_acc[s] = src_valid_i[s] && mready(s);
        if (src_valid_i[s] && !m_acc[s]) exp_ovf = 1'b1;
        m_inc[s].trans_id = src_trans_id_i[s];
        m_inc[s].result   = src_result_i[s];
        m_inc[s].ex       = src_exception_i[s];
        m_byp[s] = 1'b0;
      end
      m_n = 0;
      m_last = 0;
      for (int i = 0; i < NR_SRC; i++) begin
        m_k = (m_rr + i) % NR_SRC;
        if (m_n < NR_WB_PORTS && (mq[m_k].size() > 0 || m_acc[m_k])) begin
          if (mq[m_k].size() > 0) exp_wb[m_n] = mq[m_k].pop_front();
          else begin
            exp_wb[m_n] = m_inc[m_k];
            m_byp[m_k]  = 1'b1;
          end
          exp_valid[m_n] = 1'b1;
          m_last = m_k;
          m_n++;
        end
      end
      for (int p = 0; p < NR_WB_PORTS; p++) if (p >= m_n) exp_valid[p] = 1'b0;
      if (m_n > 0) m_rr = (m_last + 1) % NR_SRC;
      for (int s = 0; s < NR_SRC; s++)
        if (m_acc[s] && !m_byp[s]) mq[s].push_back(m_inc[s]);
    end
  end

  // Cycle-by-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    if (check_en) begin
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        vectors++;
        if (wb_valid_o[p] !== exp_valid[p] || wb_trans_id_o[p] !== exp_wb[p].trans_id ||
            wb_result_o[p] !== exp_wb[p].result || wb_exception_o[p] !== exp_wb[p].ex) begin
          miscompares++;
          $display("FAIL wb_port%0d t=%0t: got v=%0b id=%0h res=%h exc=%h, expected v=%0b id=%0h res=%h exc=%h",
                   p, $time, wb_valid_o[p], wb_trans_id_o[p], wb_result_o[p], wb_exception_o[p],
                   exp_valid[p], exp_wb[p].trans_id, exp_wb[p].result, exp_wb[p].ex);
        end
      end
      begin
        logic [NR_SRC-1:0] er;
        for (int s = 0; s < NR_SRC; s++) er[s] = mready(s);
        vectors++;
        if (src_ready_o !== er) begin
          miscompares++;
          $display("FAIL src_ready t=%0t: got %b expected %b", $time, src_ready_o, er);
        end
      end
      vectors++;
      if (overflow_o !== exp_ovf) begin
        miscompares++;
        $display("FAIL overflow t=%0t: got %b expected %b", $time, overflow_o, exp_ovf);
      end
    end
  end

  task automatic lchk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
    #1;
  endtask

  task automatic idle();
    src_valid_i = '0;
    flush_i     = 1'b0;
    rst_i       = 1'b0;
  endtask

  task automatic set_src(input int s, input logic [TRANS_ID_BITS-1:0] id, input logic [XLEN-1:0] res);
    src_valid_i[s]     = 1'b1;
    src_trans_id_i[s]  = id;
    src_result_i[s]    = res;
    src_exception_i[s] = '0;
  endtask

  task automatic do_flush();
    idle();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  int fair_a [4] = '{0, 2, 4, 1};
  int fair_b [4] = '{1, 3, 0, 2};
  logic [TRANS_ID_BITS-1:0] seen [$];
  int  sent0;
  bit  dropped;
  int  wb_count;

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; src_valid_i = '0;
    src_trans_id_i = '0; src_result_i = '0; src_exception_i = '0;
    tick();
    check_en = 1;
    tick();
    rst_i = 1'b0;
    lchk("reset_wb_valid", 64'(wb_valid_o), 64'(0));
    lchk("reset_ready", 64'(src_ready_o), 64'h1f);
    lchk("reset_ovf", 64'(overflow_o), 64'(0));
    lchk("reset_result0", 64'(wb_result_o[0]), 64'(0));

    // Single result with bypass latency of one cycle.
    set_src(1, 3'd3, 32'hDEAD_BEEF);
    tick();
    idle();
    lchk("single_valid", 64'(wb_valid_o), 64'h1);
    lchk("single_id", 64'(wb_trans_id_o[0]), 64'd3);
    lchk("single_res", 64'(wb_result_o[0]), 64'hDEAD_BEEF);
    tick();
    lchk("single_valid_drop", 64'(wb_valid_o), 64'h0);

    // Oversubscription: three sources, two ports.
    do_flush();
    set_src(0, 3'd1, 32'h11);
    set_src(1, 3'd2, 32'h22);
    set_src(3, 3'd4, 32'h44);
    tick();
    idle();
    lchk("over_valid", 64'(wb_valid_o), 64'h3);
    lchk("over_id0", 64'(wb_trans_id_o[0]), 64'd1);
    lchk("over_id1", 64'(wb_trans_id_o[1]), 64'd2);
    lchk("over_ready", 64'(src_ready_o), 64'h1f);
    tick();
    lchk("over2_valid", 64'(wb_valid_o), 64'h1);
    lchk("over2_id0", 64'(wb_trans_id_o[0]), 64'd4);
    lchk("over2_ready", 64'(src_ready_o), 64'h1f);

    // Fairness: all sources valid whenever ready, id = source index.
    do_flush();
    for (int c = 0; c < 4; c++) begin
      idle();
      for (int s = 0; s < NR_SRC; s++) if (mready(s)) set_src(s, 3'(s), 32'(s));
      tick();
      lchk("fair_p0", 64'(wb_trans_id_o[0]), 64'(fair_a[c]));
      lchk("fair_p1", 64'(wb_trans_id_o[1]), 64'(fair_b[c]));
      lchk("fair_valid", 64'(wb_valid_o), 64'h3);
    end

    // Backpressure: source 0 sends ids 0..7 in order under full contention.
    do_flush();
    sent0 = 0;
    dropped = 0;
    for (int c = 0; c < 40; c++) begin
      idle();
      if (c < 30) begin
        for (int s = 1; s < NR_SRC; s++) if (mready(s)) set_src(s, 3'(s), {4'(s), 28'h0});
        if (sent0 < 8 && mready(0)) begin
          set_src(0, 3'(sent0), 32'(sent0));
          sent0++;
        end
      end
      tick();
      if (!src_ready_o[0]) dropped = 1;
      for (int p = 0; p < NR_WB_PORTS; p++)
        if (wb_valid_o[p] && wb_result_o[p][31:28] == 4'h0) seen.push_back(wb_trans_id_o[p]);
    end
    lchk("bp_ready_dropped", 64'(dropped), 64'(1));
    lchk("bp_count", 64'(seen.size()), 64'(8));
    for (int i = 0; i < seen.size() && i < 8; i++) lchk("bp_order", 64'(seen[i]), 64'(i));
    lchk("bp_ovf", 64'(overflow_o), 64'(0));

    // Flush with source 2 holding two entries and presenting a third.
    do_flush();
    idle();
    for (int s = 0; s < NR_SRC; s++) set_src(s, 3'(s), {4'(s), 28'h100});
    tick();
    idle();
    set_src(2, 3'd6, 32'h2000_0200);
    set_src(3, 3'd3, 32'h3000_0200);
    set_src(4, 3'd4, 32'h4000_0200);
    tick();
    idle();
    set_src(0, 3'd0, 32'h0000_0300);
    set_src(2, 3'd7, 32'h2000_0300);
    tick();
    lchk("fl_src2_full", 64'(src_ready_o[2]), 64'(0));
    idle();
    flush_i = 1'b1;
    set_src(2, 3'd5, 32'h2000_0400);
    tick();
    idle();
    lchk("fl_valid", 64'(wb_valid_o), 64'h0);
    lchk("fl_ready", 64'(src_ready_o), 64'h1f);
    wb_count = 0;
    for (int c = 0; c < 4; c++) begin
      tick();
      wb_count += 32'(wb_valid_o[0]) + 32'(wb_valid_o[1]);
    end
    lchk("fl_nothing_after", 64'(wb_count), 64'(0));

    // Overflow on source 4, sticky through flush, cleared by reset mid-burst.
    idle();
    for (int s = 0; s < NR_SRC; s++) set_src(s, 3'(s), 32'(s));
    tick();
    idle();
    for (int s = 2; s < NR_SRC; s++) set_src(s, 3'(s), 32'(s));
    tick();
    idle();
    lchk("ovf_src4_full", 64'(src_ready_o[4]), 64'(0));
    set_src(4, 3'd1, 32'h4444);
    tick();
    idle();
    lchk("ovf_set", 64'(overflow_o), 64'(1));
    do_flush();
    lchk("ovf_after_flush", 64'(overflow_o), 64'(1));
    for (int c = 0; c < 3; c++) begin
      idle();
      for (int s = 0; s < NR_SRC; s++) if (mready(s)) set_src(s, 3'(c), 32'(s * 16 + c));
      tick();
    end
    rst_i = 1'b1;
    tick();
    lchk("rst_valid", 64'(wb_valid_o), 64'h0);
    lchk("rst_ids", 64'(wb_trans_id_o), 64'h0);
    lchk("rst_res", 64'(wb_result_o), 64'h0);
    lchk("rst_ovf", 64'(overflow_o), 64'(0));
    lchk("rst_ready", 64'(src_ready_o), 64'h1f);
    idle();

    // Randomized traffic: mostly ready-respecting, rare violations/flush/reset.
    for (int c = 0; c < 3000; c++) begin
      idle();
      for (int s = 0; s < NR_SRC; s++) begin
        if ($urandom_range(99) < 55 && (mready(s) || $urandom_range(199) == 0)) begin
          src_valid_i[s]           = 1'b1;
          src_trans_id_i[s]        = 3'($urandom);
          src_result_i[s]          = $urandom;
          src_exception_i[s].cause = $urandom;
          src_exception_i[s].tval  = $urandom;
          src_exception_i[s].valid = 1'($urandom);
        end
      end
      if ($urandom_range(99) == 0) flush_i = 1'b1;
      if ($urandom_range(399) == 0) rst_i = 1'b1;
      tick();
    end
    idle();
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
